// File: rtl/parking_time_tracker_if.sv
// Request/result bus of the parking time tracker.
// The gate controller drives the master side. The tracker sits on the slave side.
interface parking_time_tracker_if #(
  parameter int SLOT_W = 2,
  parameter int TIME_W = 8,
  parameter int FEE_W  = 16
) ();
  logic              req_valid;
  logic              req_type;
  logic [SLOT_W-1:0] req_slot;
  logic              req_ready;
  logic              out_valid;
  logic              out_err;
  logic [SLOT_W-1:0] out_slot;
  logic [TIME_W-1:0] out_duration;
  logic [FEE_W-1:0]  out_fee;

  modport master (
    output req_valid, req_type, req_slot,
    input  req_ready, out_valid, out_err, out_slot, out_duration, out_fee
  );

  modport slave (
    input  req_valid, req_type, req_slot,
    output req_ready, out_valid, out_err, out_slot, out_duration, out_fee
  );
endinterface

// File: rtl/parking_time_tracker.sv
// Multi-slot parking duration tracker.
// The tracker keeps a free-running time base and latches an entry time for each slot.
// On an exit it reports the duration (exit - entry, modulo 2^TIME_W) and frees the slot.
// Optional feature macro FEE_CALC_EN: when it is defined, a valid exit also reports
// fee = duration * RATE, saturated to FEE_W bits. When it is undefined, out_fee is constant 0.
//
// state  | meaning
// IDLE   | ready for a request, req_ready high
// CALC   | check the slot, subtract, update entry/occupied
// REPORT | pulse out_valid or out_err for one cycle
module parking_time_tracker #(
  parameter int TIME_W   = 8,
  parameter int SLOTS    = 4,
  parameter int SLOT_W   = 2,
  parameter int TICK_DIV = 4,
  parameter int RATE     = 3,
  parameter int FEE_W    = 16
) (
  input  logic                clk,
  input  logic                reset,
  parking_time_tracker_if.slave bus,
  output logic [SLOTS-1:0]    occupied,
  output logic [TIME_W-1:0]   now
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_REPORT} state_t;

  state_t            state_q, state_d;
  logic [PRE_W-1:0]  pre_q;
  logic [TIME_W-1:0] now_q;
  logic [TIME_W-1:0] entry_q [SLOTS];
  logic [SLOTS-1:0]  occ_q;
  logic              type_q;
  logic [SLOT_W-1:0] slot_q;
  logic [TIME_W-1:0] tcap_q;
  logic              ok_q;
  logic [SLOT_W-1:0] out_slot_q;
  logic [TIME_W-1:0] out_dur_q;
  logic [FEE_W-1:0]  out_fee_q;

  logic              transfer;
  logic              slot_ok;
  logic              occ_sel;
  logic [TIME_W-1:0] entry_sel;
  logic [TIME_W-1:0] diff;
  logic              ok_d;
  logic [TIME_W-1:0] dur_d;
  logic [FEE_W-1:0]  fee_calc;
  logic [FEE_W-1:0]  fee_d;

  assign transfer = (state_q == S_IDLE) && bus.req_valid;

  // Prescaler and time base: now advances once every TICK_DIV clocks and wraps naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_q <= '0;
      now_q <= '0;
    end else if (pre_q == PRE_W'(TICK_DIV - 1)) begin
      pre_q <= '0;
      now_q <= now_q + TIME_W'(1);
    end else begin
      pre_q <= pre_q + PRE_W'(1);
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: each accepted request takes one CALC cycle and one REPORT cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (transfer) state_d = S_CALC;
      S_CALC:   state_d = S_REPORT;
      S_REPORT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM outputs: the handshake and the one-cycle result pulses.
  always_comb begin
    bus.req_ready = (state_q == S_IDLE);
    bus.out_valid = (state_q == S_REPORT) && ok_q;
    bus.out_err   = (state_q == S_REPORT) && !ok_q;
  end

  // Capture the request. tcap_q takes the pre-edge time, so a tick at this same edge is not seen.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      type_q <= 1'b0;
      slot_q <= '0;
      tcap_q <= '0;
    end else if (transfer) begin
      type_q <= bus.req_type;
      slot_q <= bus.req_slot;
      tcap_q <= now_q;
    end
  end

  // CALC datapath: check the slot and compute the modular difference (the borrow is dropped).
  always_comb begin
    slot_ok   = int'(slot_q) < SLOTS;
    occ_sel   = slot_ok ? occ_q[slot_q] : 1'b0;
    entry_sel = slot_ok ? entry_q[slot_q] : '0;
    diff      = tcap_q - entry_sel;
    ok_d      = slot_ok && (type_q ? occ_sel : !occ_sel);
    dur_d     = (ok_d && type_q) ? diff : '0;
  end

`ifdef FEE_CALC_EN
  localparam int PW = TIME_W + 32;
  logic [PW-1:0] prod;

  // Fee: compute the product wide, then clamp it to the largest value FEE_W bits can hold.
  always_comb begin
    prod     = PW'(diff) * PW'(RATE);
    fee_calc = (prod > PW'({FEE_W{1'b1}})) ? '1 : FEE_W'(prod);
    fee_d    = (ok_d && type_q) ? fee_calc : '0;
  end
`else
  // Fee: without the fee feature there is no multiplier. RATE has no effect, so the fee is tied to zero.
  always_comb begin
    fee_calc = FEE_W'(RATE) & '0;
    fee_d    = fee_calc;
  end
`endif

  // Slot bookkeeping and result registers. The results hold their values between pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ_q      <= '0;
      ok_q       <= 1'b0;
      out_slot_q <= '0;
      out_dur_q  <= '0;
      out_fee_q  <= '0;
      for (int i = 0; i < SLOTS; i++) entry_q[i] <= '0;
    end else if (state_q == S_CALC) begin
      ok_q       <= ok_d;
      out_slot_q <= slot_q;
      out_dur_q  <= dur_d;
      out_fee_q  <= fee_d;
      if (ok_d) begin
        if (type_q) begin
          occ_q[slot_q] <= 1'b0;
        end else begin
          occ_q[slot_q]   <= 1'b1;
          entry_q[slot_q] <= tcap_q;
        end
      end
    end
  end

  assign bus.out_slot     = out_slot_q;
  assign bus.out_duration = out_dur_q;
  assign bus.out_fee      = out_fee_q;
  assign occupied         = occ_q;
  assign now              = now_q;

endmodule
